// File: rtl/branch_sequencer.sv
// ============================================================================
// branch_sequencer
//
// Purpose:
//   Sequences the branch execution element for one branch/jump at a time.
//   It accepts an instruction from decode, holds the element's operands
//   stable and releases the element from reset. It then waits for the
//   element's completion. The link value goes to the register write-back
//   port, and the resolved PC goes to fetch as a single-cycle redirect.
//   A pipeline kill or a completion timeout abandons the instruction.
//
// Ports:
//   i_clk, i_reset          clock, asynchronous active-high reset
//   i_req_*  / o_req_ready  decode request handshake and operand fields
//   i_kill                  pipeline flush, aborts the in-flight instruction
//   o_exec_reset            execution element reset (0 = run)
//   o_exec_*                latched operands presented to the element
//   i_exec_completed        element finished
//   i_exec_reg_out          element link value
//   i_exec_pc_out           element next-PC value
//   o_wb_* / i_wb_ready     link register write request to the write arbiter
//   o_redirect_*            one-cycle resolved PC pulse to fetch
//   o_branch_count          retired branches (wrapping)
//   o_taken_count           retired taken branches (wrapping)
//   o_error                 sticky completion-timeout flag
// ============================================================================
module branch_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        i_clk,
    input  logic        i_reset,

    // Decode request
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_req_pc,
    input  logic [5:0]  i_req_inst_num,
    input  logic [31:0] i_req_const16_x,
    input  logic [25:0] i_req_addr26,
    input  logic [31:0] i_req_rs,
    input  logic [31:0] i_req_rt,
    input  logic [4:0]  i_req_rd,

    // Pipeline flush
    input  logic        i_kill,

    // Branch execution element
    output logic        o_exec_reset,
    output logic [31:0] o_exec_pc,
    output logic [5:0]  o_exec_inst_num,
    output logic [31:0] o_exec_const16_x,
    output logic [25:0] o_exec_addr26,
    output logic [31:0] o_exec_rs,
    output logic [31:0] o_exec_rt,
    input  logic        i_exec_completed,
    input  logic [31:0] i_exec_reg_out,
    input  logic [31:0] i_exec_pc_out,

    // Register write-back
    output logic        o_wb_valid,
    input  logic        i_wb_ready,
    output logic [4:0]  o_wb_reg,
    output logic [31:0] o_wb_data,

    // Fetch redirect
    output logic        o_redirect_valid,
    output logic [31:0] o_redirect_pc,
    output logic        o_redirect_taken,

    // Statistics and status
    output logic [31:0] o_branch_count,
    output logic [31:0] o_taken_count,
    output logic        o_error
);

    // Instruction numbers that write a link register
    localparam logic [5:0] INST_BGEZAL = 6'd37;
    localparam logic [5:0] INST_BLTZAL = 6'd38;
    localparam logic [5:0] INST_JAL    = 6'd40;
    localparam logic [5:0] INST_JALR   = 6'd42;

    localparam logic [4:0] LINK_REG_RA = 5'd31;

    // The counter only has to hold values up to TIMEOUT_CYCLES-1
    localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        WB,
        DONE
    } state_t;

    state_t             r_state;
    logic [TIMER_W-1:0] r_timer;
    logic [4:0]         r_rd;
    logic               r_taken;

    logic               w_is_link;
    logic [4:0]         w_link_reg;
    logic [31:0]        w_seq_pc;
    logic               w_taken;

    // Link classification of the latched instruction. Numbers outside the
    // valid range fall into the default, so they never write a register.
    always_comb begin
        w_is_link  = 1'b0;
        w_link_reg = LINK_REG_RA;
        case (o_exec_inst_num)
            INST_BGEZAL, INST_BLTZAL, INST_JAL: begin
                w_is_link  = 1'b1;
                w_link_reg = LINK_REG_RA;
            end
            INST_JALR: begin
                w_is_link  = 1'b1;
                w_link_reg = r_rd;
            end
            default: begin
                w_is_link  = 1'b0;
                w_link_reg = LINK_REG_RA;
            end
        endcase
    end

    // A branch counts as taken whenever the resolved PC differs from the
    // sequential successor. The successor address wraps modulo 2^32.
    assign w_seq_pc = o_exec_pc + 32'd4;
    assign w_taken  = (i_exec_pc_out != w_seq_pc);

    // Main controller. Every output is a register. o_exec_reset is driven
    // low only while in EXEC, so the element drops its completed flag
    // before the next instruction. i_kill is examined first in every
    // state it affects, which gives it priority over completion,
    // write-back grant and timeout.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state          <= IDLE;
            r_timer          <= '0;
            r_rd             <= '0;
            r_taken          <= 1'b0;
            o_req_ready      <= 1'b1;
            o_exec_reset     <= 1'b1;
            o_exec_pc        <= '0;
            o_exec_inst_num  <= '0;
            o_exec_const16_x <= '0;
            o_exec_addr26    <= '0;
            o_exec_rs        <= '0;
            o_exec_rt        <= '0;
            o_wb_valid       <= 1'b0;
            o_wb_reg         <= '0;
            o_wb_data        <= '0;
            o_redirect_valid <= 1'b0;
            o_redirect_pc    <= '0;
            o_redirect_taken <= 1'b0;
            o_branch_count   <= '0;
            o_taken_count    <= '0;
            o_error          <= 1'b0;
        end else begin
            o_redirect_valid <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (!i_kill && i_req_valid) begin
                        o_exec_pc        <= i_req_pc;
                        o_exec_inst_num  <= i_req_inst_num;
                        o_exec_const16_x <= i_req_const16_x;
                        o_exec_addr26    <= i_req_addr26;
                        o_exec_rs        <= i_req_rs;
                        o_exec_rt        <= i_req_rt;
                        r_rd             <= i_req_rd;
                        r_timer          <= '0;
                        o_exec_reset     <= 1'b0;
                        o_req_ready      <= 1'b0;
                        r_state          <= EXEC;
                    end
                end

                EXEC: begin
                    if (i_kill) begin
                        o_exec_reset <= 1'b1;
                        o_req_ready  <= 1'b1;
                        r_state      <= IDLE;
                    end else if (i_exec_completed) begin
                        o_redirect_pc <= i_exec_pc_out;
                        o_wb_data     <= i_exec_reg_out;
                        r_taken       <= w_taken;
                        o_exec_reset  <= 1'b1;
                        if (w_is_link) begin
                            o_wb_valid <= 1'b1;
                            o_wb_reg   <= w_link_reg;
                            r_state    <= WB;
                        end else begin
                            // DONE presents the redirect for exactly one cycle
                            o_redirect_valid <= 1'b1;
                            o_redirect_taken <= w_taken;
                            r_state          <= DONE;
                        end
                    end else if (r_timer == TIMER_LAST) begin
                        // The element never answered; abandon without any
                        // redirect, write-back or statistics update
                        o_error      <= 1'b1;
                        o_exec_reset <= 1'b1;
                        o_req_ready  <= 1'b1;
                        r_state      <= IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                WB: begin
                    if (i_kill) begin
                        o_wb_valid  <= 1'b0;
                        o_req_ready <= 1'b1;
                        r_state     <= IDLE;
                    end else if (i_wb_ready) begin
                        o_wb_valid       <= 1'b0;
                        o_redirect_valid <= 1'b1;
                        o_redirect_taken <= r_taken;
                        r_state          <= DONE;
                    end
                end

                DONE: begin
                    // The redirect is already visible, so a kill here is
                    // ignored and the instruction retires normally
                    o_branch_count <= o_branch_count + 32'd1;
                    if (r_taken) begin
                        o_taken_count <= o_taken_count + 32'd1;
                    end
                    o_req_ready <= 1'b1;
                    r_state     <= IDLE;
                end

                default: begin
                    o_exec_reset <= 1'b1;
                    o_wb_valid   <= 1'b0;
                    o_req_ready  <= 1'b1;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_sequencer.sv
// ============================================================================
// tb_branch_sequencer
//
// Purpose:
//   Self-checking bench for branch_sequencer. A small stub stands in for
//   the branch execution element. It raises completed one cycle after its
//   reset is released. pc_out and reg_out come from the current vector.
//   Table vectors cover the normal retire paths. Hand-written sequences
//   cover kill, timeout and reset corner cases.
//
// Ports: none (top-level bench)
// ============================================================================
module tb_branch_sequencer;

    logic        clk;
    logic        reset;
    logic        reqValid;
    logic        reqReady;
    logic [31:0] reqPc;
    logic [5:0]  reqInstNum;
    logic [31:0] reqConst16x;
    logic [25:0] reqAddr26;
    logic [31:0] reqRs;
    logic [31:0] reqRt;
    logic [4:0]  reqRd;
    logic        kill;
    logic        execReset;
    logic [31:0] execPc;
    logic [5:0]  execInstNum;
    logic [31:0] execConst16x;
    logic [25:0] execAddr26;
    logic [31:0] execRs;
    logic [31:0] execRt;
    logic        execCompleted;
    logic [31:0] execRegOut;
    logic [31:0] execPcOut;
    logic        wbValid;
    logic        wbReady;
    logic [4:0]  wbReg;
    logic [31:0] wbData;
    logic        redirectValid;
    logic [31:0] redirectPc;
    logic        redirectTaken;
    logic [31:0] branchCount;
    logic [31:0] takenCount;
    logic        errorFlag;

    logic        stubEnable;

    int checks;
    int errors;
    int expBranch;
    int expTaken;

    // One directed vector: request fields, element responses, expectations
    typedef struct packed {
        logic [31:0] pc;
        logic [5:0]  inst;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] c16;
        logic [25:0] addr26;
        logic [4:0]  rd;
        logic [31:0] pcOut;
        logic [31:0] regOut;
        logic        isLink;
        logic [4:0]  expWbReg;
        logic [31:0] expWbData;
        logic [31:0] expRedirPc;
        logic        expTaken;
        logic [3:0]  stall;
    } vec_t;

    localparam int NUM_VECS = 8;
    vec_t vecs [NUM_VECS];

    branch_sequencer #(.TIMEOUT_CYCLES(15)) dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_req_valid      (reqValid),
        .o_req_ready      (reqReady),
        .i_req_pc         (reqPc),
        .i_req_inst_num   (reqInstNum),
        .i_req_const16_x  (reqConst16x),
        .i_req_addr26     (reqAddr26),
        .i_req_rs         (reqRs),
        .i_req_rt         (reqRt),
        .i_req_rd         (reqRd),
        .i_kill           (kill),
        .o_exec_reset     (execReset),
        .o_exec_pc        (execPc),
        .o_exec_inst_num  (execInstNum),
        .o_exec_const16_x (execConst16x),
        .o_exec_addr26    (execAddr26),
        .o_exec_rs        (execRs),
        .o_exec_rt        (execRt),
        .i_exec_completed (execCompleted),
        .i_exec_reg_out   (execRegOut),
        .i_exec_pc_out    (execPcOut),
        .o_wb_valid       (wbValid),
        .i_wb_ready       (wbReady),
        .o_wb_reg         (wbReg),
        .o_wb_data        (wbData),
        .o_redirect_valid (redirectValid),
        .o_redirect_pc    (redirectPc),
        .o_redirect_taken (redirectTaken),
        .o_branch_count   (branchCount),
        .o_taken_count    (takenCount),
        .o_error          (errorFlag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Execution element stand-in: completes one cycle after release
    always @(posedge clk or posedge execReset) begin
        if (execReset) begin
            execCompleted <= 1'b0;
        end else if (stubEnable) begin
            execCompleted <= 1'b1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic driveReq(input vec_t v);
        reqPc       = v.pc;
        reqInstNum  = v.inst;
        reqRs       = v.rs;
        reqRt       = v.rt;
        reqConst16x = v.c16;
        reqAddr26   = v.addr26;
        reqRd       = v.rd;
        execPcOut   = v.pcOut;
        execRegOut  = v.regOut;
    endtask

    // Runs one vector from accept to retire and checks latency, routing
    // and the statistics counters
    task automatic applyStimulus(input vec_t v, input string tag);
        int wbCycles;
        int redirCount;
        int redirCycle;
        int expCycle;
        logic [31:0] seenPc;
        logic seenTaken;
        wbCycles   = 0;
        redirCount = 0;
        redirCycle = 0;
        seenPc     = '0;
        seenTaken  = 1'b0;
        @(negedge clk);
        checkOutput($sformatf("%s req_ready before accept", tag), {31'd0, reqReady}, 32'd1);
        driveReq(v);
        reqValid = 1'b1;
        wbReady  = 1'b0;
        @(posedge clk);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) begin
                reqValid = 1'b0;
                checkOutput($sformatf("%s exec_reset released", tag), {31'd0, execReset}, 32'd0);
                checkOutput($sformatf("%s exec_pc", tag), execPc, v.pc);
                checkOutput($sformatf("%s exec_inst_num", tag), {26'd0, execInstNum}, {26'd0, v.inst});
                checkOutput($sformatf("%s exec_rs", tag), execRs, v.rs);
                checkOutput($sformatf("%s exec_rt", tag), execRt, v.rt);
                checkOutput($sformatf("%s exec_const16_x", tag), execConst16x, v.c16);
                checkOutput($sformatf("%s exec_addr26", tag), {6'd0, execAddr26}, {6'd0, v.addr26});
            end
            if (wbValid) begin
                wbCycles++;
                checkOutput($sformatf("%s wb_reg", tag), {27'd0, wbReg}, {27'd0, v.expWbReg});
                checkOutput($sformatf("%s wb_data", tag), wbData, v.expWbData);
            end
            wbReady = wbValid && (wbCycles > int'(v.stall));
            if (redirectValid) begin
                redirCount++;
                redirCycle = c;
                seenPc     = redirectPc;
                seenTaken  = redirectTaken;
            end
        end
        wbReady  = 1'b0;
        expCycle = v.isLink ? (4 + int'(v.stall)) : 3;
        checkOutput($sformatf("%s redirect pulses", tag), redirCount, 1);
        checkOutput($sformatf("%s redirect cycle", tag), redirCycle, expCycle);
        checkOutput($sformatf("%s redirect_pc", tag), seenPc, v.expRedirPc);
        checkOutput($sformatf("%s redirect_taken", tag), {31'd0, seenTaken}, {31'd0, v.expTaken});
        checkOutput($sformatf("%s wb_valid cycles", tag), wbCycles,
                    v.isLink ? (int'(v.stall) + 1) : 0);
        expBranch++;
        if (v.expTaken) expTaken++;
        checkOutput($sformatf("%s branch_count", tag), branchCount, expBranch);
        checkOutput($sformatf("%s taken_count", tag), takenCount, expTaken);
        checkOutput($sformatf("%s exec_reset idle", tag), {31'd0, execReset}, 32'd1);
    endtask

    // Counts redirect pulses over a few cycles after an aborted instruction
    task automatic checkQuiet(input string tag);
        int pulses;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (redirectValid) pulses++;
        end
        checkOutput($sformatf("%s no redirect", tag), pulses, 0);
        checkOutput($sformatf("%s branch_count held", tag), branchCount, expBranch);
        checkOutput($sformatf("%s taken_count held", tag), takenCount, expTaken);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput($sformatf("%s req_ready", tag), {31'd0, reqReady}, 32'd1);
        checkOutput($sformatf("%s exec_reset", tag), {31'd0, execReset}, 32'd1);
        checkOutput($sformatf("%s wb_valid", tag), {31'd0, wbValid}, 32'd0);
        checkOutput($sformatf("%s redirect_valid", tag), {31'd0, redirectValid}, 32'd0);
        checkOutput($sformatf("%s redirect_taken", tag), {31'd0, redirectTaken}, 32'd0);
        checkOutput($sformatf("%s error", tag), {31'd0, errorFlag}, 32'd0);
        checkOutput($sformatf("%s branch_count", tag), branchCount, 32'd0);
        checkOutput($sformatf("%s taken_count", tag), takenCount, 32'd0);
        checkOutput($sformatf("%s exec_pc", tag), execPc, 32'd0);
        checkOutput($sformatf("%s exec_rs", tag), execRs, 32'd0);
        checkOutput($sformatf("%s wb_reg", tag), {27'd0, wbReg}, 32'd0);
        checkOutput($sformatf("%s wb_data", tag), wbData, 32'd0);
        checkOutput($sformatf("%s redirect_pc", tag), redirectPc, 32'd0);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        expBranch  = 0;
        expTaken   = 0;
        reset      = 1'b1;
        reqValid   = 1'b0;
        kill       = 1'b0;
        wbReady    = 1'b0;
        stubEnable = 1'b1;
        reqPc = '0; reqInstNum = '0; reqConst16x = '0; reqAddr26 = '0;
        reqRs = '0; reqRt = '0; reqRd = '0; execPcOut = '0; execRegOut = '0;

        //            pc            inst   rs            rt     c16           addr26    rd     pcOut         regOut        lnk  wbReg  wbData        redirPc       tkn  stall
        vecs[0] = '{32'h0000_0100, 6'd32, 32'd5,        32'd5, 32'h10,       26'h0,    5'd0,  32'h0000_0140, 32'h0000_0104, 1'b0, 5'd0,  32'h0,        32'h0000_0140, 1'b1, 4'd0};
        vecs[1] = '{32'h0000_0200, 6'd36, 32'd1,        32'd0, 32'h0,        26'h0,    5'd0,  32'h0000_0204, 32'h0000_0204, 1'b0, 5'd0,  32'h0,        32'h0000_0204, 1'b0, 4'd0};
        vecs[2] = '{32'h0000_0300, 6'd42, 32'h1000,     32'd0, 32'h0,        26'h0,    5'd7,  32'h0000_1000, 32'h0000_0304, 1'b1, 5'd7,  32'h0000_0304, 32'h0000_1000, 1'b1, 4'd3};
        vecs[3] = '{32'h4000_0010, 6'd40, 32'd0,        32'd0, 32'h0,        26'h10,   5'd0,  32'h4000_0040, 32'h4000_0014, 1'b1, 5'd31, 32'h4000_0014, 32'h4000_0040, 1'b1, 4'd0};
        vecs[4] = '{32'h0000_0500, 6'd37, 32'd0,        32'd0, 32'hFFFF_FFFF, 26'h0,   5'd9,  32'h0000_04FC, 32'h0000_0504, 1'b1, 5'd31, 32'h0000_0504, 32'h0000_04FC, 1'b1, 4'd1};
        vecs[5] = '{32'hFFFF_FFFC, 6'd50, 32'd3,        32'd4, 32'h0,        26'h0,    5'd12, 32'h0000_0000, 32'h0000_0000, 1'b0, 5'd0,  32'h0,        32'h0000_0000, 1'b0, 4'd0};
        vecs[6] = '{32'h0000_0600, 6'd33, 32'd8,        32'd8, 32'h20,       26'h0,    5'd5,  32'h0000_0604, 32'h0000_0604, 1'b0, 5'd0,  32'h0,        32'h0000_0604, 1'b0, 4'd0};
        vecs[7] = '{32'h0000_0700, 6'd39, 32'd0,        32'd0, 32'h0,        26'h100,  5'd0,  32'h0000_0400, 32'h0000_0704, 1'b0, 5'd0,  32'h0,        32'h0000_0400, 1'b1, 4'd0};

        repeat (2) @(negedge clk);
        checkResetState("reset");
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // kill in IDLE beats req_valid
        @(negedge clk);
        driveReq(vecs[0]);
        reqValid = 1'b1;
        kill     = 1'b1;
        @(negedge clk);
        reqValid = 1'b0;
        kill     = 1'b0;
        checkOutput("kill idle req_ready", {31'd0, reqReady}, 32'd1);
        checkOutput("kill idle exec_reset", {31'd0, execReset}, 32'd1);

        // kill in EXEC on the same edge the element reports completion
        @(negedge clk);
        driveReq(vecs[0]);
        reqValid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reqValid = 1'b0;
        @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        checkOutput("kill exec exec_reset", {31'd0, execReset}, 32'd1);
        checkOutput("kill exec req_ready", {31'd0, reqReady}, 32'd1);
        checkOutput("kill exec redirect_valid", {31'd0, redirectValid}, 32'd0);
        checkOutput("kill exec wb_valid", {31'd0, wbValid}, 32'd0);
        checkQuiet("kill exec");

        // kill in WB together with wb_ready
        @(negedge clk);
        driveReq(vecs[2]);
        reqValid = 1'b1;
        wbReady  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reqValid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("kill wb wb_valid before", {31'd0, wbValid}, 32'd1);
        kill    = 1'b1;
        wbReady = 1'b1;
        @(negedge clk);
        kill    = 1'b0;
        wbReady = 1'b0;
        checkOutput("kill wb wb_valid", {31'd0, wbValid}, 32'd0);
        checkOutput("kill wb req_ready", {31'd0, reqReady}, 32'd1);
        checkOutput("kill wb exec_reset", {31'd0, execReset}, 32'd1);
        checkOutput("kill wb redirect_valid", {31'd0, redirectValid}, 32'd0);
        checkQuiet("kill wb");

        // kill in DONE is ignored; the instruction still retires
        @(negedge clk);
        driveReq(vecs[1]);
        reqValid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reqValid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("kill done redirect_valid", {31'd0, redirectValid}, 32'd1);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        expBranch++;
        checkOutput("kill done branch_count", branchCount, expBranch);
        checkOutput("kill done taken_count", takenCount, expTaken);
        checkOutput("kill done req_ready", {31'd0, reqReady}, 32'd1);

        // Timeout: the element never completes
        @(negedge clk);
        stubEnable = 1'b0;
        driveReq(vecs[0]);
        reqValid = 1'b1;
        @(posedge clk);
        begin
            int pulses;
            pulses = 0;
            for (int c = 1; c <= 18; c++) begin
                @(negedge clk);
                if (c == 1) reqValid = 1'b0;
                if (redirectValid || wbValid) pulses++;
                if (c == 15) begin
                    checkOutput("timeout error before", {31'd0, errorFlag}, 32'd0);
                    checkOutput("timeout req_ready before", {31'd0, reqReady}, 32'd0);
                end
                if (c == 16) begin
                    checkOutput("timeout error set", {31'd0, errorFlag}, 32'd1);
                    checkOutput("timeout req_ready", {31'd0, reqReady}, 32'd1);
                    checkOutput("timeout exec_reset", {31'd0, execReset}, 32'd1);
                end
            end
            checkOutput("timeout no redirect or wb", pulses, 0);
            checkOutput("timeout branch_count held", branchCount, expBranch);
            checkOutput("timeout taken_count held", takenCount, expTaken);
        end
        stubEnable = 1'b1;

        // error is sticky across later instructions
        applyStimulus(vecs[3], "post-timeout");
        checkOutput("error sticky", {31'd0, errorFlag}, 32'd1);

        // Reset in the middle of EXEC clears everything at once
        @(negedge clk);
        stubEnable = 1'b0;
        driveReq(vecs[2]);
        reqValid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reqValid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkResetState("mid-exec reset");
        @(negedge clk);
        reset      = 1'b0;
        stubEnable = 1'b1;
        expBranch  = 0;
        expTaken   = 0;
        applyStimulus(vecs[0], "after reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

endmodule
